// File: rtl/baccarat_datapath_if.sv
// Load strobes from the baccarat state machine and the hand/score results returned to it.
interface baccarat_datapath_if;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic [3:0] pcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  pcard3, pscore, dscore,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output pcard3, pscore, dscore,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat datapath: 1..13 card source, six hand registers, mod-10 scores, 7-seg digits.
// Define BACCARAT_SCORE_REG_EN to register pscore/dscore one edge behind the card registers.
module baccarat_datapath #(
    parameter int unsigned START_CARD = 1
) (
    input  logic               slow_clock,
    input  logic               resetb,
    baccarat_datapath_if.slave bus
);
    localparam logic [3:0] DEAL_RST = 4'(START_CARD);

    logic [3:0] r_deal;
    logic [3:0] r_pcard1;
    logic [3:0] r_pcard2;
    logic [3:0] r_pcard3;
    logic [3:0] r_dcard1;
    logic [3:0] r_dcard2;
    logic [3:0] r_dcard3;
    logic [3:0] w_pscore;
    logic [3:0] w_dscore;

    // Loads capture the pre-increment deal value; simultaneous loads share it.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_deal   <= DEAL_RST;
            r_pcard1 <= '0;
            r_pcard2 <= '0;
            r_pcard3 <= '0;
            r_dcard1 <= '0;
            r_dcard2 <= '0;
            r_dcard3 <= '0;
        end else begin
            r_deal <= (r_deal == 4'd13) ? 4'd1 : r_deal + 4'd1;
            if (bus.load_pcard1) r_pcard1 <= r_deal;
            if (bus.load_pcard2) r_pcard2 <= r_deal;
            if (bus.load_pcard3) r_pcard3 <= r_deal;
            if (bus.load_dcard1) r_dcard1 <= r_deal;
            if (bus.load_dcard2) r_dcard2 <= r_deal;
            if (bus.load_dcard3) r_dcard3 <= r_deal;
        end
    end

    function automatic logic [4:0] card_val(input logic [3:0] c);
        return (c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    // Sum of three cards is at most 27, so mod 10 needs only one subtraction of 10 or 20.
    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = card_val(a) + card_val(b) + card_val(c);
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd1:    s = 7'b0001000;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b1000000;
            4'd11:   s = 7'b1100001;
            4'd12:   s = 7'b0011000;
            4'd13:   s = 7'b0001001;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        w_pscore = hand_score(r_pcard1, r_pcard2, r_pcard3);
        w_dscore = hand_score(r_dcard1, r_dcard2, r_dcard3);
    end

`ifdef BACCARAT_SCORE_REG_EN
    logic [3:0] r_pscore;
    logic [3:0] r_dscore;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_pscore <= '0;
            r_dscore <= '0;
        end else begin
            r_pscore <= w_pscore;
            r_dscore <= w_dscore;
        end
    end

    assign bus.pscore = r_pscore;
    assign bus.dscore = r_dscore;
`else
    assign bus.pscore = w_pscore;
    assign bus.dscore = w_dscore;
`endif

    assign bus.pcard3 = r_pcard3;
    assign bus.HEX0   = seg7(r_pcard1);
    assign bus.HEX1   = seg7(r_pcard2);
    assign bus.HEX2   = seg7(r_pcard3);
    assign bus.HEX3   = seg7(r_dcard1);
    assign bus.HEX4   = seg7(r_dcard2);
    assign bus.HEX5   = seg7(r_dcard3);
endmodule

// File: tb/tb_baccarat_datapath.sv
// Scoreboard bench for baccarat_datapath: directed hands plus random loads and resets.
// Expected outputs come from a card-list model using the dealing formula and plain mod-10 arithmetic.
module tb_baccarat_datapath;
    localparam int START = 1;

    localparam logic [6:0] SEG [16] = '{
        7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
        7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    baccarat_datapath_if bif ();

    baccarat_datapath #(.START_CARD(START)) dut (
        .slow_clock (clk),
        .resetb     (rst_n),
        .bus        (bif)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [53:0] q [$];

    // cards[] order: p1, p2, p3, d1, d2, d3; k counts edges since reset release
    int cards [6];
    int k;
    int ps_prev, ds_prev;

    function automatic int cval(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int score3(input int a, input int b, input int c);
        return (cval(a) + cval(b) + cval(c)) % 10;
    endfunction

    function automatic logic [53:0] pack_exp(input int ps, input int ds);
        return {4'(cards[2]), 4'(ps), 4'(ds),
                SEG[cards[5]], SEG[cards[4]], SEG[cards[3]],
                SEG[cards[2]], SEG[cards[1]], SEG[cards[0]]};
    endfunction

    function automatic logic [53:0] dut_out();
        return {bif.pcard3, bif.pscore, bif.dscore,
                bif.HEX5, bif.HEX4, bif.HEX3, bif.HEX2, bif.HEX1, bif.HEX0};
    endfunction

    task automatic cmp(input string name, input logic [53:0] act, input logic [53:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp4(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int next_deal();
        return ((START - 1 + k) % 13) + 1;
    endfunction

    task automatic model_reset();
        foreach (cards[i]) cards[i] = 0;
        k = 0;
    endtask

    task automatic set_loads(input logic [5:0] l);
        bif.load_pcard1 = l[0];
        bif.load_pcard2 = l[1];
        bif.load_pcard3 = l[2];
        bif.load_dcard1 = l[3];
        bif.load_dcard2 = l[4];
        bif.load_dcard3 = l[5];
    endtask

    // Called at a negedge: drive loads for the next posedge, push the expected result, wait a cycle.
    task automatic step(input logic [5:0] l);
        int d;
        set_loads(l);
        d = next_deal();
        k++;
        ps_prev = score3(cards[0], cards[1], cards[2]);
        ds_prev = score3(cards[3], cards[4], cards[5]);
        for (int i = 0; i < 6; i++)
            if (l[i]) cards[i] = d;
`ifdef BACCARAT_SCORE_REG_EN
        q.push_back(pack_exp(ps_prev, ds_prev));
`else
        q.push_back(pack_exp(score3(cards[0], cards[1], cards[2]),
                             score3(cards[3], cards[4], cards[5])));
`endif
        @(negedge clk);
    endtask

    task automatic load_card(input int slot, input int val);
        int guard = 0;
        while (next_deal() != val && guard < 13) begin
            step('0);
            guard++;
        end
        step(6'(1 << slot));
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries still pending, required 0", q.size());
            q.delete();
        end
    endtask

    // Asserts reset away from the clock edge and checks outputs before any edge; returns at a negedge.
    task automatic do_reset();
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_loads('0);
        model_reset();
        #1;
        cmp("async_reset", dut_out(), pack_exp(0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [53:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("edge", dut_out(), e);
            end
        end
    end

    initial begin : stimulus
        set_loads('0);
        model_reset();
        #3;
        cmp("power_on_reset", dut_out(), pack_exp(0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Full hand p1, d1, p2, d2, p3, d3 on edges 1..6, one idle edge for registered scores
        step(6'b000001);
        step(6'b001000);
        step(6'b000010);
        step(6'b010000);
        step(6'b000100);
        step(6'b100000);
        step('0);
        drain();
        cmp4("hand_pscore", {3'b0, bif.pscore}, 7'd9);
        cmp4("hand_dscore", {3'b0, bif.dscore}, 7'd2);
        cmp4("hand_pcard3", {3'b0, bif.pcard3}, 7'd5);
        cmp4("hand_HEX2", bif.HEX2, 7'b0010010);

        // Mid-hand asynchronous reset
        do_reset();

        // 12 idle edges then p1 gets 13 (K), next edge p2 wraps to 1
        for (int i = 0; i < 12; i++) step('0);
        step(6'b000001);
        step(6'b000010);
        step('0);
        drain();
        cmp4("wrap_HEX0_K", bif.HEX0, 7'b0001001);
        cmp4("wrap_pscore", {3'b0, bif.pscore}, 7'd1);

        // Modulo via sum 24
        do_reset();
        load_card(0, 9);
        load_card(1, 8);
        load_card(2, 7);
        step('0);
        drain();
        cmp4("mod_pscore", {3'b0, bif.pscore}, 7'd4);

        // Simultaneous p1/d1 load on edge 3
        do_reset();
        step('0);
        step('0);
        step(6'b001001);
        step('0);
        drain();
        cmp4("simul_pscore", {3'b0, bif.pscore}, 7'd3);
        cmp4("simul_dscore", {3'b0, bif.dscore}, 7'd3);

        // Reload overwrites
        step(6'b000001);
        step('0);

        // Random loads with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(6'($urandom) & 6'($urandom));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        step('0);
        step('0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
